// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared DATA_W-bit register.
// Optional grant locking is enabled with `define DFF_ARB_LOCK_EN.
module dff_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          lock,
`endif
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  last_id,
  output logic [15:0]                 wr_count
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     last_id_q, last_id_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [ID_W-1:0]     arb_base_c;
  logic [ID_W-1:0]     win_id_c;
  logic                win_vld_c;
  logic [ID_W-1:0]     idx_c;
  logic                lock_hold_c;

  // In GRANT the current winner becomes last_id at this edge, so it is the search base.
  always_comb begin
    arb_base_c = (state_q == S_GRANT) ? cur_id_q : last_id_q;
    win_id_c   = '0;
    win_vld_c  = 1'b0;
    idx_c      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = ID_W'((32'(arb_base_c) + k) % NUM_REQ);
      if (!win_vld_c && req[idx_c]) begin
        win_vld_c = 1'b1;
        win_id_c  = idx_c;
      end
    end
  end

`ifdef DFF_ARB_LOCK_EN
  logic [2:0] hold_q, hold_d;

  // Seven locked extensions after the first grant gives at most eight writes.
  always_comb begin
    lock_hold_c = (state_q == S_GRANT) && lock[cur_id_q] && (hold_q != 3'd7);
    hold_d      = lock_hold_c ? hold_q + 3'd1 : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= 3'd0;
    else     hold_q <= hold_d;
  end
`else
  always_comb begin
    lock_hold_c = 1'b0;
  end
`endif

  // Next-state, commit and grant logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cur_id_d  = cur_id_q;
    q_d       = q_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld_c) begin
          state_d  = S_GRANT;
          gnt_d    = NUM_REQ'(1) << win_id_c;
          cur_id_d = win_id_c;
        end
      end
      S_GRANT: begin
        q_d       = wdata[32'(cur_id_q)*DATA_W +: DATA_W];
        last_id_d = cur_id_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
        if (lock_hold_c) begin
          state_d = S_GRANT;
        end else if (win_vld_c) begin
          gnt_d    = NUM_REQ'(1) << win_id_c;
          cur_id_d = win_id_c;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      cur_id_q  <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cur_id_q  <= cur_id_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign q        = q_q;
  assign busy     = busy_q;
  assign last_id  = last_id_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Self-checking bench for dff_write_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_dff_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [1:0]     last_id;
  logic [15:0]    wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model: current grant index (-1 = none), register, count, last winner, lock holds.
  int m_grant, m_q, m_cnt, m_last, m_hold;

  dff_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .q(q), .busy(busy), .last_id(last_id), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit held;
    held = 1'b0;
    if (rst) begin
      m_grant = -1; m_q = 0; m_cnt = 0; m_last = N - 1; m_hold = 0;
    end else begin
      if (m_grant >= 0) begin
        m_q = int'(wdata[m_grant*W +: W]);
        if (m_cnt < 65535) m_cnt++;
        m_last = m_grant;
`ifdef DFF_ARB_LOCK_EN
        if (lock[m_grant] && m_hold < 7) begin
          m_hold++;
          held = 1'b1;
        end
`endif
      end
      if (!held) begin
        m_grant = pick();
        m_hold  = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] one;
    one = 1;
    return (m_grant >= 0) ? N'(one << m_grant) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; lock = '0; wdata = $urandom;
    tick(); tick();
    checks += 5;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
    if (last_id !== 2'd3) begin errors++; $display("FAIL reset_last_id: got %0d want 3", last_id); end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; wdata = $urandom; wdata[2*W +: W] = 8'hA5;
    tick();
    checks += 2;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    req = '0;
    tick();
    checks += 5;
    if (q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h want a5", q); end
    if (wr_count !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", wr_count); end
    if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    if (last_id !== 2'd2) begin errors++; $display("FAIL single_last_id: got %0d want 2", last_id); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] one;
    one = 1;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wdata = $urandom;
      tick();
      checks += 3;
      if (gnt !== N'(one << (i % N))) begin errors++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, gnt, N'(one << (i % N))); end
      if (busy !== 1'b1) begin errors++; $display("FAIL fair_busy[%0d]: got %b want 1", i, busy); end
      if (wr_count !== 16'(i)) begin errors++; $display("FAIL fair_cnt[%0d]: got %0d want %0d", i, wr_count, i); end
    end
    tick();
    checks += 2;
    if (wr_count !== 16'd8) begin errors++; $display("FAIL fair_total: got %0d want 8", wr_count); end
    if (q !== 8'(m_q)) begin errors++; $display("FAIL fair_q: got %h want %h", q, 8'(m_q)); end
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100; wdata = $urandom;
    tick();
    req = 4'b0011;
    tick();
    checks += 2;
    if (last_id !== 2'd2) begin errors++; $display("FAIL wrap_last2: got %0d want 2", last_id); end
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
    tick();
    checks += 2;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1: got %b want 0010", gnt); end
    if (last_id !== 2'd0) begin errors++; $display("FAIL wrap_last0: got %0d want 0", last_id); end
    req = '0;
    tick();
    checks += 3;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL wrap_idle: got %b want 0000", gnt); end
    if (last_id !== 2'd1) begin errors++; $display("FAIL wrap_last1: got %0d want 1", last_id); end
    if (wr_count !== 16'd3) begin errors++; $display("FAIL wrap_cnt: got %0d want 3", wr_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; wdata = $urandom; wdata[1*W +: W] = 8'h3C;
    tick();
    checks += 1;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt: got %b want 0010", gnt); end
    rst = 1'b1;
    tick();
    checks += 4;
    if (q !== 8'h00) begin errors++; $display("FAIL rmid_q: got %h want 00", q); end
    if (wr_count !== 16'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", wr_count); end
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt_clr: got %b want 0000", gnt); end
    if (last_id !== 2'd3) begin errors++; $display("FAIL rmid_last: got %0d want 3", last_id); end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      req   = N'($urandom);
      wdata = $urandom;
      lock  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      tick();
      checks += 5;
      if (gnt !== exp_gnt()) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, gnt, exp_gnt()); end
      if (q !== 8'(m_q)) begin errors++; $display("FAIL rand_q[%0d]: got %h want %h", i, q, 8'(m_q)); end
      if (busy !== (m_grant >= 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_grant >= 0); end
      if (last_id !== 2'(m_last)) begin errors++; $display("FAIL rand_last[%0d]: got %0d want %0d", i, last_id, m_last); end
      if (wr_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, wr_count, m_cnt); end
    end
    rst = 1'b0; req = '0; lock = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 65545; i++) begin
      wdata = $urandom;
      tick();
    end
    checks += 3;
    if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h want ffff", wr_count); end
    if (wr_count !== 16'(m_cnt)) begin errors++; $display("FAIL sat_model: got %h want %h", wr_count, 16'(m_cnt)); end
    if (q !== 8'(m_q)) begin errors++; $display("FAIL sat_q: got %h want %h", q, 8'(m_q)); end
    req = '0;
  endtask

`ifdef DFF_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      wdata = $urandom;
      tick();
      checks += 1;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want 0001", i, gnt); end
    end
    tick();
    checks += 2;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_release: got %b want 0010", gnt); end
    if (wr_count !== 16'd8) begin errors++; $display("FAIL lock_cnt: got %0d want 8", wr_count); end
    req = '0; lock = '0;
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; lock = '0; wdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_reset_mid();
`ifdef DFF_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin arbiter that shares one DATA_W-bit D flip-flop register between NUM_REQ requesters. It sequences every write through a registered request/grant handshake, so exactly one requester's data is captured per clock. It sits between the requesting blocks and the shared storage register, which it instantiates internally and drives out on `q`.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `DATA_W`, 8: width of the shared register and of each write-data lane.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  input  NUM_REQ  per-requester write request, level-sensitive.
- `wdata`  input  NUM_REQ*DATA_W  write data; lane i is bits [i*DATA_W +: DATA_W].
- `lock`  input  NUM_REQ  per-requester hold-grant; present only with `DFF_ARB_LOCK_EN`.
- `gnt`  output  NUM_REQ  registered one-hot grant; all zero when no write is in progress.
- `q`  output  DATA_W  shared register contents.
- `busy`  output  1  high while any grant is active.
- `last_id`  output  $clog2(NUM_REQ)  index of the most recent winner.
- `wr_count`  output  16  number of committed writes, saturating at 16'hFFFF.

## Operation
- Reset values:
  - State is IDLE.
  - `gnt` = 0, `q` = 0, `busy` = 0, `wr_count` = 0.
  - `last_id` = NUM_REQ-1, so requester 0 has first priority after reset.
- States:
  - IDLE: no grant. If any `req` bit is high, register the winner's one-hot grant and go to GRANT. Otherwise stay in IDLE.
  - GRANT: the winner's `gnt` bit is high for this cycle. At the closing edge:
    - `q` <= winner's `wdata` lane; `wr_count` increments; `last_id` <= winner.
    - The next winner is then arbitrated from the current `req`. If one exists, stay in GRANT with the new `gnt`; otherwise go to IDLE.
- Arbitration:
  - Search order is `last_id`+1, `last_id`+2, … modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - The first asserted `req` in that order wins.
  - The winner is computed combinationally from `req` and `last_id`. It is used only when a new grant is registered.
- A write commits unconditionally once granted. If `req` drops during the grant cycle, the write still commits, using `wdata` as it is in that cycle.
- A requester that keeps `req` high after its grant re-enters arbitration with the lowest priority.
- `busy` equals (state == GRANT).
- `wr_count` holds at 16'hFFFF and never wraps.
- Reset during GRANT: the pending write is discarded, `q` returns to 0, and all other reset values apply on that edge.

## Timing
- `req` sampled high at edge k -> `gnt` high in the cycle after edge k -> `q` updated at edge k+1.
- Request-to-data latency is 2 edges.
- With requests pending continuously, back-to-back grants give a throughput of 1 write per cycle with no idle gap.
- `wdata` for lane i must be stable throughout the cycle in which `gnt[i]` is high.
- `gnt` and `q` are register outputs; there is no combinational path from inputs to outputs.
- A `req` that rises in the same cycle that another requester's grant ends is considered in that cycle's arbitration.

## Configuration
- `DFF_ARB_LOCK_EN` defined:
  - Adds the `lock` port.
  - In GRANT, if the current winner's `lock` bit is high at the edge, the winner keeps the grant for another write. `last_id` is still updated, but no new arbitration takes place.
  - A grant may be locked for at most 8 consecutive writes. After that, arbitration is forced and the locking requester has lowest priority.
  - A 3-bit hold counter tracks locked writes and resets to 0 when the grant changes.
- `DFF_ARB_LOCK_EN` undefined: no `lock` port, no hold counter; every write is arbitrated.

## Test plan
- Reset: assert `rst` for 2 cycles with all `req` high -> `gnt` = 0, `q` = 0, `busy` = 0, `wr_count` = 0, `last_id` = 3.
- Single requester: `req` = 4'b0100, lane 2 = 8'hA5 -> `gnt` = 4'b0100 one cycle after the request edge; `q` = 8'hA5 on the next edge; `wr_count` = 1; then back to IDLE.
- Fairness: `req` = 4'b1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 back to back; `wr_count` = 8; `busy` stays high.
- Wrap-around and sparse requests: `last_id` = 2, `req` = 4'b0011 -> requester 0 wins, then requester 1.
- Reset mid-grant: `rst` in the cycle where `gnt` = 4'b0010 with lane 1 = 8'h3C -> `q` stays 0; `wr_count` unchanged at 0.
- With `DFF_ARB_LOCK_EN`: `req` = 4'b0011, `lock[0]` held high -> requester 0 gets 8 consecutive writes, then requester 1 is granted.
